// File: rtl/bit_column_encoder.sv
// Bit-column encoder: turns a sign-magnitude weight group into one beat per non-zero
// magnitude bit column, in the order ZCIP reports them. Optional macro: ZCE_FALLBACK_EN.
module bit_column_encoder #(
  parameter int unsigned GROUP_SIZE   = 8,
  parameter int unsigned FALLBACK_CYC = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [GROUP_SIZE*8-1:0] in_weights,
  output logic [6:0]              index_vector,
  input  logic [2:0]              zc_shift_offset,
  input  logic                    zc_valid,
  input  logic                    zc_done,
  output logic                    col_valid,
  output logic [GROUP_SIZE-1:0]   col_bits,
  output logic [GROUP_SIZE-1:0]   col_sign,
  output logic [2:0]              col_offset,
  output logic                    col_last,
  output logic                    col_empty
);

  typedef enum logic [1:0] {StIdle, StWait, StStream, StEmpty} state_e;

  state_e                  r_state, w_state_d;
  logic [GROUP_SIZE*8-1:0] r_weights, w_weights_d;
  logic [GROUP_SIZE-1:0]   r_sign, w_sign_d, w_sign_new;
  logic [6:0]              r_mask, w_mask_d, w_mask_new;
  logic [6:0]              r_served, w_served_d;
  logic [6:0]              r_index, w_index_d;
  logic [6:0]              w_pending, w_sel_onehot, w_pending_after;
  logic [7:0]              w_pending8;
  logic                    w_hit, w_fire;
  logic [2:0]              w_sel_off;
  logic [GROUP_SIZE-1:0]   w_col_bits;

  logic                    r_col_valid, w_col_valid_d;
  logic                    r_col_last, w_col_last_d;
  logic                    r_col_empty, w_col_empty_d;
  logic [GROUP_SIZE-1:0]   r_col_bits, w_col_bits_d;
  logic [GROUP_SIZE-1:0]   r_col_sign, w_col_sign_d;
  logic [2:0]              r_col_offset, w_col_offset_d;

  logic                    w_fb_fire;
  logic [2:0]              w_fb_off;

  // Offset 7 lands on the padded zero bit, so it can never count as a hit.
  assign w_pending  = r_mask & ~r_served;
  assign w_pending8 = {1'b0, w_pending};
  assign w_hit      = zc_valid & ~zc_done & w_pending8[zc_shift_offset];

`ifdef ZCE_FALLBACK_EN
  localparam int unsigned CntW = (FALLBACK_CYC > 1) ? $clog2(FALLBACK_CYC) : 1;

  logic [CntW-1:0] r_stall_cnt, w_stall_cnt_d;

  always_comb begin
    w_fb_off      = 3'd0;
    w_fb_fire     = 1'b0;
    w_stall_cnt_d = '0;
    for (int b = 0; b < 7; b++) begin
      if (w_pending[b]) w_fb_off = 3'(b);
    end
    if (r_state == StStream && !w_hit) begin
      if (r_stall_cnt == CntW'(FALLBACK_CYC - 1)) begin
        w_fb_fire = 1'b1;
      end else begin
        w_stall_cnt_d = r_stall_cnt + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else begin
      r_stall_cnt <= w_stall_cnt_d;
    end
  end
`else
  logic w_unused_fallback;
  assign w_fb_fire         = 1'b0;
  assign w_fb_off          = 3'd0;
  assign w_unused_fallback = (FALLBACK_CYC == 0);
`endif

  always_comb begin
    w_mask_new = '0;
    w_sign_new = '0;
    for (int i = 0; i < GROUP_SIZE; i++) begin
      w_mask_new    = w_mask_new | in_weights[8*i +: 7];
      w_sign_new[i] = in_weights[8*i + 7];
    end

    w_fire          = (r_state == StStream) & (w_hit | w_fb_fire);
    w_sel_off       = w_hit ? zc_shift_offset : w_fb_off;
    w_sel_onehot    = 7'(8'd1 << w_sel_off);
    w_pending_after = w_pending & ~w_sel_onehot;
    for (int i = 0; i < GROUP_SIZE; i++) begin
      w_col_bits[i] = r_weights[8*i + int'(w_sel_off)];
    end

    w_state_d      = r_state;
    w_weights_d    = r_weights;
    w_sign_d       = r_sign;
    w_mask_d       = r_mask;
    w_served_d     = r_served;
    w_col_valid_d  = 1'b0;
    w_col_last_d   = 1'b0;
    w_col_empty_d  = 1'b0;
    w_col_bits_d   = '0;
    w_col_sign_d   = '0;
    w_col_offset_d = 3'd0;

    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_weights_d = in_weights;
          w_sign_d    = w_sign_new;
          w_mask_d    = w_mask_new;
          w_served_d  = '0;
          if (w_mask_new == '0) begin
            // The empty beat is registered here so it shows while in EMPTY.
            w_state_d     = StEmpty;
            w_col_valid_d = 1'b1;
            w_col_last_d  = 1'b1;
            w_col_empty_d = 1'b1;
            w_col_sign_d  = w_sign_new;
          end else begin
            w_state_d = StWait;
          end
        end
      end
      StWait: w_state_d = StStream;
      StStream: begin
        if (w_fire) begin
          w_served_d     = r_served | w_sel_onehot;
          w_col_valid_d  = 1'b1;
          w_col_offset_d = w_sel_off;
          w_col_bits_d   = w_col_bits;
          w_col_sign_d   = r_sign;
          if (w_pending_after == '0) begin
            w_col_last_d = 1'b1;
            w_state_d    = StIdle;
          end
        end
      end
      StEmpty: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase

    if (w_state_d == StWait || w_state_d == StStream) begin
      w_index_d = w_mask_d & ~w_served_d;
    end else begin
      w_index_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_weights    <= '0;
      r_sign       <= '0;
      r_mask       <= '0;
      r_served     <= '0;
      r_index      <= '0;
      r_col_valid  <= 1'b0;
      r_col_last   <= 1'b0;
      r_col_empty  <= 1'b0;
      r_col_bits   <= '0;
      r_col_sign   <= '0;
      r_col_offset <= 3'd0;
    end else begin
      r_state      <= w_state_d;
      r_weights    <= w_weights_d;
      r_sign       <= w_sign_d;
      r_mask       <= w_mask_d;
      r_served     <= w_served_d;
      r_index      <= w_index_d;
      r_col_valid  <= w_col_valid_d;
      r_col_last   <= w_col_last_d;
      r_col_empty  <= w_col_empty_d;
      r_col_bits   <= w_col_bits_d;
      r_col_sign   <= w_col_sign_d;
      r_col_offset <= w_col_offset_d;
    end
  end

  assign in_ready     = (r_state == StIdle) & ~rst;
  assign index_vector = r_index;
  assign col_valid    = r_col_valid;
  assign col_last     = r_col_last;
  assign col_empty    = r_col_empty;
  assign col_bits     = r_col_bits;
  assign col_sign     = r_col_sign;
  assign col_offset   = r_col_offset;

endmodule

// File: doc/bit_column_encoder.md
Name: bit_column_encoder

Overview:
- Producer/consumer partner of the zero-column index processor (ZCIP) in the BitWave datapath.
- Accepts a group of sign-magnitude weights and derives the 7-bit non-zero bit-column index vector that drives ZCIP.
- Consumes ZCIP's shift-offset stream and emits one bit-column beat per non-zero column to the bit-column engine (BCE).
- Retires each group once every non-zero column has been emitted; all-zero groups get a single empty beat.

Parameters:
- GROUP_SIZE, 8, number of weights per group (one bit per weight in each column beat).
- FALLBACK_CYC, 4, consecutive non-hit STREAM cycles before fallback selection (used only with the optional feature).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  weight group valid.
- in_ready  output  1  block can accept a group (high only in IDLE).
- in_weights  input  GROUP_SIZE*8  weight w occupies bits [8w+7:8w]; bit 7 is sign, bits [6:0] are magnitude.
- index_vector  output  7  pending non-zero columns, to ZCIP.
- zc_shift_offset  input  3  column offset from ZCIP.
- zc_valid  input  1  ZCIP offset valid.
- zc_done  input  1  ZCIP reports no column found.
- col_valid  output  1  column beat valid.
- col_bits  output  GROUP_SIZE  magnitude bit col_offset of each weight.
- col_sign  output  GROUP_SIZE  sign bits of the group.
- col_offset  output  3  column index of this beat.
- col_last  output  1  final beat of the group.
- col_empty  output  1  group was all-zero magnitude.

Behaviour:
- Reset values: state IDLE; all outputs 0; in_ready=0 while rst is high, 1 on the first cycle after release; internal weight, sign, mask and served registers cleared.
- Reset mid-group drops the group entirely. No beats are emitted for it.
- States: IDLE, WAIT, STREAM, EMPTY.
- IDLE:
  - in_ready=1, combinational from state.
  - On in_valid, latch weights and signs, and compute mask[b] = OR over all weights of magnitude bit b; clear served.
  - mask==0 goes to EMPTY; otherwise goes to WAIT.
- index_vector = mask & ~served, registered. It is 0 in IDLE and EMPTY.
- WAIT: one cycle so ZCIP can register index_vector, then go to STREAM.
- STREAM hit:
  - A hit is zc_valid=1, zc_done=0, and pending[zc_shift_offset]=1.
  - On a hit, next cycle: col_valid=1, col_offset=zc_shift_offset, col_bits[w]=magnitude bit zc_shift_offset of weight w, col_sign=latched signs; served bit set.
- STREAM non-hit:
  - Offset 7, zc_done=1, offsets of already-served or zero columns, and zc_valid=0 are ignored.
  - No beat is produced; the state is unchanged.
- STREAM retire: when a hit clears the last pending bit, that beat has col_last=1 and the state returns to IDLE. in_ready is high on the same cycle as the last beat.
- EMPTY: one beat with col_valid=1, col_empty=1, col_last=1, col_bits=0, col_offset=0; then IDLE.
- Beats are emitted one per cycle at most. Each non-zero column is emitted exactly once per group, in the order ZCIP reports it.
- Minimum latency: group accepted at cycle t, index_vector valid at t+1, ZCIP offset at t+2, first col_valid at t+3.
- col_valid, col_last and col_empty are single-cycle pulses. There is no downstream backpressure.

Optional Feature:
- Macro: ZCE_FALLBACK_EN.
- Defined:
  - A counter tracks consecutive non-hit STREAM cycles.
  - When it reaches FALLBACK_CYC, the encoder self-selects the highest pending column and emits it as a normal beat, with col_last if applicable. The counter then resets; any hit also resets it.
- Undefined: STREAM waits indefinitely for hits; the counter logic is absent.

Test Plan:
- Reset release: after rst is deasserted, in_ready=1, col_valid=0, index_vector=0.
- All weights 0x05, ZCIP model returns 2 then 0:
  - index_vector=0000101, then 0000001.
  - Beats are (off2, bits 0xFF) then (off0, bits 0xFF, last).
  - First beat arrives 3 cycles after acceptance.
- Weights 0x00 ×8: single beat with col_empty=1, col_last=1, col_bits=0x00; in_ready returns next cycle.
- Weight0=0xC0, others 0x01:
  - Mask 1000001; beats are off6 with bits 0x01, then off0 with bits 0xFE.
  - col_sign=0x01 on both beats.
- Stale and duplicate offsets: inject offset 6 twice, then 7 with zc_done=1, then 0 → exactly two beats; duplicates and done are ignored.
- Stalled ZCIP (zc_valid=0) with mask 0001000:
  - With ZCE_FALLBACK_EN, FALLBACK_CYC=4: beat off3 with last after 4 idle cycles.
  - Without the macro: no beat. Asserting rst mid-wait clears all outputs.
